sine_lut_arbiter: RTL and testbench

SINE_LUT_ARBITER -- requirements
Module: sine_lut_arbiter

---
 rtl/sine_lut_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sine_lut_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_arbiter.sv
// Round-robin arbiter sharing one combinational sine_table among NREQ requesters.
// Optional cosine phase offset per requester is enabled with `define SINE_ARB_COS_EN.
module sine_lut_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int ROM_DEPTH = 224,
  parameter  int ROM_WIDTH = 8,
  localparam int ADDRW     = $clog2(4*ROM_DEPTH),
  localparam int FULL      = 4*ROM_DEPTH,
  localparam int SELW      = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*ADDRW-1:0]         req_id,
`ifdef SINE_ARB_COS_EN
  input  logic [NREQ-1:0]               req_cos,
`endif
  output logic [NREQ-1:0]               req_ready,
  output logic [ADDRW-1:0]              lut_id,
  input  logic signed [2*ROM_WIDTH-1:0] lut_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic signed [2*ROM_WIDTH-1:0] resp_data,
  output logic [SELW-1:0]               resp_sel,
  output logic                          resp_err,
  output logic                          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                        state_q;
  logic [SELW-1:0]               rr_ptr_q;
  logic [SELW-1:0]               sel_q;
  logic                          err_q;
  logic [ADDRW-1:0]              lut_id_q;
  logic                          resp_valid_q;
  logic signed [2*ROM_WIDTH-1:0] resp_data_q;
  logic [SELW-1:0]               resp_sel_q;
  logic                          resp_err_q;

  logic                          any_s;
  logic                          hit_s;
  logic [SELW-1:0]               gidx_s;
  logic [SELW:0]                 pos_s;
  logic [SELW:0]                 sum_s;
  logic [NREQ-1:0]               grant_oh_s;
  logic [ADDRW-1:0]              gid_s;
  logic [ADDRW-1:0]              eff_s;
  logic                          oor_s;
  logic [NREQ-1:0]               req_ready_s;
  logic [SELW-1:0]               rr_next_s;
`ifdef SINE_ARB_COS_EN
  logic                          gcos_s;
  logic [ADDRW:0]                shift_s;
`endif

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    any_s  = 1'b0;
    hit_s  = 1'b0;
    gidx_s = '0;
    pos_s  = '0;
    sum_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s  = {1'b0, rr_ptr_q} + (SELW+1)'(i);
      pos_s  = (sum_s >= (SELW+1)'(NREQ)) ? (sum_s - (SELW+1)'(NREQ)) : sum_s;
      hit_s  = !any_s && req_valid[pos_s[SELW-1:0]];
      gidx_s = hit_s ? pos_s[SELW-1:0] : gidx_s;
      any_s  = any_s | hit_s;
    end
  end

  // Select the winner's id (and cosine flag) and build its one-hot grant.
  always_comb begin
    gid_s      = '0;
    grant_oh_s = '0;
`ifdef SINE_ARB_COS_EN
    gcos_s     = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (gidx_s == SELW'(k)) begin
        gid_s         = req_id[k*ADDRW +: ADDRW];
        grant_oh_s[k] = 1'b1;
`ifdef SINE_ARB_COS_EN
        gcos_s        = req_cos[k];
`endif
      end else begin
        grant_oh_s[k] = 1'b0;
      end
    end
  end

  // Range check uses the raw id; the cosine offset only moves the table address.
  always_comb begin
    oor_s = ({1'b0, gid_s} >= (ADDRW+1)'(FULL));
`ifdef SINE_ARB_COS_EN
    shift_s = {1'b0, gid_s} + (ADDRW+1)'(ROM_DEPTH);
    if (gcos_s) begin
      eff_s = (shift_s >= (ADDRW+1)'(FULL)) ? ADDRW'(shift_s - (ADDRW+1)'(FULL))
                                              : ADDRW'(shift_s);
    end else begin
      eff_s = gid_s;
    end
`else
    eff_s = gid_s;
`endif
  end

  // Grant strobe is only offered in IDLE and is suppressed while reset is asserted.
  always_comb begin
    if ((state_q == ST_IDLE) && !rst && any_s) begin
      req_ready_s = grant_oh_s;
    end else begin
      req_ready_s = '0;
    end
  end

  assign rr_next_s = (sel_q == SELW'(NREQ-1)) ? '0 : (sel_q + SELW'(1));

  // Transaction FSM: IDLE (grant) -> LOOKUP (sample table) -> RESP (handshake).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      err_q        <= 1'b0;
      lut_id_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_sel_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_s) begin
            lut_id_q <= eff_s;
            sel_q    <= gidx_s;
            err_q    <= oor_s;
            state_q  <= ST_LOOKUP;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= err_q ? '0 : lut_data;
          resp_sel_q   <= sel_q;
          resp_err_q   <= err_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= rr_next_s;
            state_q      <= ST_IDLE;
          end else begin
            state_q      <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign lut_id     = lut_id_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_sel   = resp_sel_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sine_lut_arbiter.sv
// Directed bench for sine_lut_arbiter; the table stub returns {6'b0,id} ^ 16'hC300.
module tb_sine_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_id;
  logic [3:0]  req_ready;
  logic [9:0]  lut_id;
  logic [15:0] lut_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_sel;
  logic        resp_err;
  logic        busy;
`ifdef SINE_ARB_COS_EN
  logic [3:0]  req_cos;
`endif

  int errors = 0;
  int checks = 0;

  logic [9:0]  rr_ids  [4] = '{10'd10, 10'd20, 10'd30, 10'd40};
  logic [15:0] rr_data [4] = '{16'hC30A, 16'hC314, 16'hC31E, 16'hC328};

  always #5 clk = ~clk;

  assign lut_data = {6'b0, lut_id} ^ 16'hC300;

  sine_lut_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_id     (req_id),
`ifdef SINE_ARB_COS_EN
    .req_cos    (req_cos),
`endif
    .req_ready  (req_ready),
    .lut_id     (lut_id),
    .lut_data   (lut_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_sel   (resp_sel),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int k, input logic [9:0] v);
    req_id[k*10 +: 10] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 4'b0001;
    req_id     = 40'd0;
    resp_ready = 1'b0;
`ifdef SINE_ARB_COS_EN
    req_cos    = 4'b0000;
`endif
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_lut_id", 32'(lut_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_sel", 32'(resp_sel), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    // Single request, requester 0, id 64.
    set_id(0, 10'd64);
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("t1_grant", 32'(req_ready), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_lookup_ready", 32'(req_ready), 32'd0);
    chk("t1_lut_id", 32'(lut_id), 32'd64);
    chk("t1_lookup_busy", 32'(busy), 32'd1);
    chk("t1_lookup_valid", 32'(resp_valid), 32'd0);
    req_valid = 4'b0000;
    tick();
    chk("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_resp_data", 32'(resp_data), 32'hC340);
    chk("t1_resp_sel", 32'(resp_sel), 32'd0);
    chk("t1_resp_err", 32'(resp_err), 32'd0);
    tick();
    chk("t1_done_valid", 32'(resp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_lut_hold", 32'(lut_id), 32'd64);

    // All four requesters valid from reset: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) set_id(k, rr_ids[k]);
    resp_ready = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (t % 4)));
      tick();
      chk("rr_lut_id", 32'(lut_id), 32'(rr_ids[t % 4]));
      tick();
      chk("rr_sel", 32'(resp_sel), 32'(t % 4));
      chk("rr_data", 32'(resp_data), 32'(rr_data[t % 4]));
      tick();
    end

    // rr_ptr now 1: requester 2 wins with out-of-range id 900; consumer stalls.
    req_valid  = 4'b1101;
    set_id(2, 10'd900);
    set_id(3, 10'd5);
    set_id(0, 10'd7);
    resp_ready = 1'b0;
    #1;
    chk("t3_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1001;
    chk("t3_lut_id", 32'(lut_id), 32'd900);
    tick();
    chk("t3_valid", 32'(resp_valid), 32'd1);
    chk("t3_err", 32'(resp_err), 32'd1);
    chk("t3_data", 32'(resp_data), 32'd0);
    chk("t3_sel", 32'(resp_sel), 32'd2);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_err", 32'(resp_err), 32'd1);
      chk("stall_data", 32'(resp_data), 32'd0);
      chk("stall_sel", 32'(resp_sel), 32'd2);
      chk("stall_no_grant", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    resp_ready = 1'b1;
    tick();
    chk("t3_released", 32'(resp_valid), 32'd0);
    chk("t3_next_grant", 32'(req_ready), 32'h8);
    tick();
    chk("t4_lut_id", 32'(lut_id), 32'd5);
    req_valid = 4'b0011;

    // Reset during LOOKUP aborts the transaction and clears rr_ptr.
    rst = 1'b1;
    tick();
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_lut_id", 32'(lut_id), 32'd0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("abort_rr_ptr", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t5_data", 32'(resp_data), 32'hC314);
    chk("t5_sel", 32'(resp_sel), 32'd1);
    tick();

`ifdef SINE_ARB_COS_EN
    req_valid = 4'b0001;
    req_cos   = 4'b0001;
    set_id(0, 10'd0);
    #1;
    tick();
    chk("cos_id0", 32'(lut_id), 32'd224);
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b0010;
    req_cos   = 4'b0010;
    set_id(1, 10'd800);
    #1;
    tick();
    chk("cos_id800", 32'(lut_id), 32'd128);
    req_valid = 4'b0000;
    tick();
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
